// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter and Gray write pointer / full logic for an async FIFO.
// Latency: 0 cycles (grant, wdata, wren and waddr are combinational); wptr and wr_full are registered.
// Backpressure: gnt is withheld while wr_full=1. FIFO_WR_ALMOST_FULL_EN adds wr_almost_full.
package fifo_gray_pkg;
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
endpackage

module fifo_wr_arbiter
    import fifo_gray_pkg::*;
#(
    parameter int DATASIZE = 8,
    parameter int DEPTH    = 8,
    parameter int NREQ     = 4,
    localparam int ADDRSIZE = $clog2(DEPTH)
`ifdef FIFO_WR_ALMOST_FULL_EN
    , parameter int AFULL_THRESH = DEPTH - 2
`endif
) (
    input  logic                     wclk,
    input  logic                     wrst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DATASIZE-1:0] req_data,
    output logic [NREQ-1:0]          gnt,
    input  logic [ADDRSIZE:0]        wq2_rptr,
    output logic [DATASIZE-1:0]      wdata,
    output logic                     wren,
    output logic [ADDRSIZE-1:0]      waddr,
    output logic [ADDRSIZE:0]        wptr,
    output logic                     wr_full
`ifdef FIFO_WR_ALMOST_FULL_EN
    , output logic                   wr_almost_full
`endif
);
    localparam int PW = ADDRSIZE + 1;
    localparam int IW = $clog2(NREQ);

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rptr_full;
    logic [IW-1:0] last;
    logic [IW-1:0] grant_idx;
    logic          run;

    // run holds grants off until the first edge after reset release.
    always_comb begin
        int  idx;
        logic found;
        gnt       = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        if (run && !wr_full) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = int'(last) + k;
                if (idx >= NREQ) idx = idx - NREQ;
                if (!found && req[idx]) begin
                    found     = 1'b1;
                    gnt[idx]  = 1'b1;
                    grant_idx = IW'(idx);
                end
            end
        end
    end

    always_comb begin
        wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) wdata = wdata | req_data[i*DATASIZE +: DATASIZE];
        end
    end

    assign wren       = |gnt;
    assign waddr      = wbin[ADDRSIZE-1:0];
    assign wbin_next  = wbin + PW'(wren);
    assign wgray_next = PW'(bin2gray(32'(wbin_next)));
    assign rptr_full  = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin    <= '0;
            wptr    <= '0;
            wr_full <= 1'b0;
            last    <= IW'(NREQ - 1);
            run     <= 1'b0;
        end else begin
            run     <= 1'b1;
            wbin    <= wbin_next;
            wptr    <= wgray_next;
            wr_full <= (wgray_next == rptr_full);
            if (wren) last <= grant_idx;
        end
    end

`ifdef FIFO_WR_ALMOST_FULL_EN
    logic [PW-1:0] fill;
    assign fill = wbin_next - PW'(gray2bin(32'(wq2_rptr)));

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) wr_almost_full <= 1'b0;
        else         wr_almost_full <= (32'(fill) >= 32'(AFULL_THRESH));
    end
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (DATASIZE=8, DEPTH=8, NREQ=4); checks grants, datapath, pointers and full.
module tb_fifo_wr_arbiter;
    logic        wclk;
    logic        wrst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [3:0]  wq2_rptr;
    logic [7:0]  wdata;
    logic        wren;
    logic [2:0]  waddr;
    logic [3:0]  wptr;
    logic        wr_full;
`ifdef FIFO_WR_ALMOST_FULL_EN
    logic        wr_almost_full;
`endif

    int n_chk = 0;
    int n_err = 0;

    logic [3:0] gray_tab [16];
    logic [3:0] gnt_exp  [5];
    logic [7:0] dat_exp  [5];
    logic [3:0] pending;

    fifo_wr_arbiter #(
        .DATASIZE(8),
        .DEPTH(8),
        .NREQ(4)
`ifdef FIFO_WR_ALMOST_FULL_EN
        , .AFULL_THRESH(6)
`endif
    ) dut (
        .wclk(wclk),
        .wrst_n(wrst_n),
        .req(req),
        .req_data(req_data),
        .gnt(gnt),
        .wq2_rptr(wq2_rptr),
        .wdata(wdata),
        .wren(wren),
        .waddr(waddr),
        .wptr(wptr),
        .wr_full(wr_full)
`ifdef FIFO_WR_ALMOST_FULL_EN
        , .wr_almost_full(wr_almost_full)
`endif
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Protocol monitor: an ungranted request must still be asserted at the next edge.
    always @(posedge wclk) begin
        if (!wrst_n) begin
            pending <= '0;
        end else begin
            if (pending != 4'b0) chk("req_hold", 32'(req & pending), 32'(pending));
            pending <= req & ~gnt;
        end
    end

    task automatic do_reset(input logic [3:0] r);
        wrst_n   = 1'b0;
        req      = r;
        wq2_rptr = 4'b0;
        repeat (2) @(posedge wclk);
        @(negedge wclk);
        wrst_n = 1'b1;
        @(posedge wclk);
        #1;
    endtask

    initial begin
        gray_tab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                     4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
        gnt_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        dat_exp  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        pending  = '0;

        // Reset with all requests held.
        wrst_n   = 1'b0;
        req      = 4'b1111;
        wq2_rptr = 4'b0;
        repeat (2) @(posedge wclk);
        @(negedge wclk);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_wren", 32'(wren), 32'h0);
        chk("rst_wptr", 32'(wptr), 32'h0);
        chk("rst_full", 32'(wr_full), 32'h0);
        wrst_n = 1'b1;
        #1;
        chk("release_gnt", 32'(gnt), 32'h0);
        @(posedge wclk);

        // Round-robin rotation with the reader keeping up.
        for (int k = 0; k < 5; k++) begin
            @(negedge wclk);
            chk("rr_gnt", 32'(gnt), 32'(gnt_exp[k]));
            chk("rr_wdata", 32'(wdata), 32'(dat_exp[k]));
            chk("rr_waddr", 32'(waddr), 32'(k));
            @(posedge wclk);
            #1;
            wq2_rptr = gray_tab[k+1];
        end
        @(negedge wclk);
        chk("rr_wptr", 32'(wptr), 32'h7);
        chk("rr_full", 32'(wr_full), 32'h0);

        // Fill to full with the reader frozen, then release one slot.
        do_reset(4'b0100);
        for (int k = 0; k < 8; k++) begin
            @(negedge wclk);
            chk("fill_gnt", 32'(gnt), 32'h4);
            chk("fill_waddr", 32'(waddr), 32'(k));
            chk("fill_full", 32'(wr_full), 32'h0);
`ifdef FIFO_WR_ALMOST_FULL_EN
            chk("fill_afull", 32'(wr_almost_full), (k >= 6) ? 32'h1 : 32'h0);
`endif
            @(posedge wclk);
        end
        @(negedge wclk);
        chk("full_set", 32'(wr_full), 32'h1);
        chk("full_gnt", 32'(gnt), 32'h0);
        chk("full_wren", 32'(wren), 32'h0);
        chk("full_wptr", 32'(wptr), 32'hC);
`ifdef FIFO_WR_ALMOST_FULL_EN
        chk("full_afull", 32'(wr_almost_full), 32'h1);
`endif
        @(posedge wclk);
        #1;
        wq2_rptr = 4'b0001;
        @(negedge wclk);
        chk("full_hold", 32'(wr_full), 32'h1);
        @(negedge wclk);
        chk("full_clear", 32'(wr_full), 32'h0);
        chk("refill_gnt", 32'(gnt), 32'h4);
        chk("refill_waddr", 32'(waddr), 32'h0);
        chk("refill_wdata", 32'(wdata), 32'h33);
        @(negedge wclk);
        chk("refull", 32'(wr_full), 32'h1);
        chk("refull_wptr", 32'(wptr), 32'hD);

        // 20 writes while draining: Gray pointer wraps through 1000 -> 0000.
        do_reset(4'b0001);
        for (int k = 0; k < 20; k++) begin
            @(negedge wclk);
            chk("wrap_gnt", 32'(gnt), 32'h1);
            chk("wrap_waddr", 32'(waddr), 32'(k % 8));
            chk("wrap_wptr", 32'(wptr), 32'(gray_tab[k % 16]));
            chk("wrap_full", 32'(wr_full), 32'h0);
            @(posedge wclk);
            #1;
            wq2_rptr = gray_tab[(k + 1) % 16];
        end

        // Reset asserted mid-burst at wbin=5.
        do_reset(4'b1111);
        for (int k = 0; k < 5; k++) begin
            @(posedge wclk);
            #1;
            wq2_rptr = gray_tab[k+1];
        end
        chk("mid_waddr", 32'(waddr), 32'h5);
        #1;
        wrst_n = 1'b0;
        #1;
        chk("mid_gnt", 32'(gnt), 32'h0);
        chk("mid_wren", 32'(wren), 32'h0);
        chk("mid_wptr", 32'(wptr), 32'h0);
        chk("mid_waddr_clr", 32'(waddr), 32'h0);
        chk("mid_full", 32'(wr_full), 32'h0);
        wq2_rptr = 4'b0;
        @(negedge wclk);
        wrst_n = 1'b1;
        @(posedge wclk);
        @(negedge wclk);
        chk("regrant_gnt", 32'(gnt), 32'h1);
        chk("regrant_waddr", 32'(waddr), 32'h0);
        chk("regrant_wdata", 32'(wdata), 32'h11);

        wrst_n = 1'b0;
        req    = 4'b0;
        #20;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
